// File: rtl/axi4_pkg.sv
// rtl/axi4_pkg.sv - AXI4 read-channel field bundles, burst types and response codes
package axi4_pkg;
  localparam int AXI_ID_W = 4;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2
  } axi_burst_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'd1;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
  localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

  typedef struct packed {
    logic                arvalid;
    logic [AXI_ID_W-1:0] arid;
    logic [31:0]         araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
  } ar_m;

  typedef struct packed {
    logic rready;
  } r_m;

  typedef struct packed {
    logic arready;
  } ar_s;

  typedef struct packed {
    logic                rvalid;
    logic [AXI_ID_W-1:0] rid;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic                rlast;
  } r_s;
endpackage

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V subsystem types: read responder FSM states
package riscv_pkg;
  typedef logic [1:0] rd_rsp_state_t;

  localparam rd_rsp_state_t RD_RSP_IDLE  = 2'd0;
  localparam rd_rsp_state_t RD_RSP_BURST = 2'd1;
  localparam rd_rsp_state_t RD_RSP_DRAIN = 2'd2;
endpackage

// File: rtl/riscv_axi_burst_addr.sv
// rtl/riscv_axi_burst_addr.sv - combinational AXI4 next-beat address for FIXED/INCR/WRAP bursts
module riscv_axi_burst_addr
  import axi4_pkg::*;
(
  input  logic [31:0] i_addr,
  input  logic [7:0]  i_len,
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_burst,
  output logic [31:0] o_next_addr
);
  logic [31:0] w_step;
  logic [31:0] w_bound;
  logic [31:0] w_base;
  logic [31:0] w_incr;

  assign w_step  = 32'd1 << i_size;
  // Wrap window is (len+1) beats wide; legal WRAP lengths make it a power of two.
  assign w_bound = ({24'd0, i_len} + 32'd1) << i_size;
  assign w_base  = i_addr & ~(w_bound - 32'd1);
  assign w_incr  = i_addr + w_step;

  always_comb begin
    o_next_addr = w_incr;
    case (i_burst)
      AXI_BURST_FIXED: o_next_addr = i_addr;
      AXI_BURST_WRAP:  if (w_incr == w_base + w_bound) o_next_addr = w_base;
      default:         o_next_addr = w_incr;
    endcase
  end
endmodule

// File: rtl/riscv_axi_rd_responder.sv
// rtl/riscv_axi_rd_responder.sv - AXI4 AR/R slave over a 1-cycle synchronous read memory
// Optional: RISCV_AXI_RD_UNALIGNED_ERR_EN turns unaligned araddr into an all-SLVERR burst.
module riscv_axi_rd_responder
  import axi4_pkg::*;
  import riscv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] SIZE_BYTES = 32'h0001_0000,
  parameter int          MEM_AW     = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  ar_m               AXI_AR_M,
  input  r_m                AXI_R_M,
  output ar_s               AXI_AR_S,
  output r_s                AXI_R_S,
  output logic              mem_rd_en,
  output logic [MEM_AW-1:0] mem_rd_addr,
  input  logic [31:0]       mem_rd_data
);
  rd_rsp_state_t       r_state;
  logic [AXI_ID_W-1:0] r_id;
  logic [31:0]         r_addr;
  logic [7:0]          r_len;
  logic [7:0]          r_beats_left;
  logic [2:0]          r_size;
  logic [1:0]          r_burst;
  logic                r_burst_err;

  logic [31:0] r_fdata [2];
  logic [1:0]  r_fresp [2];
  logic        r_flast [2];
  logic        r_fpend [2];
  logic        r_wptr;
  logic        r_rptr;
  logic [1:0]  r_count;

  logic        w_ar_hs;
  logic [31:0] w_ar_mask;
  logic        w_ar_bad;
  logic        w_ar_err;
  logic [31:0] w_ar_addr;
  logic        w_issue;
  logic        w_pop;
  logic [31:0] w_rel;
  logic        w_in_range;
  logic [1:0]  w_beat_resp;
  logic [31:0] w_next_addr;

  assign w_ar_hs   = (r_state == RD_RSP_IDLE) && AXI_AR_M.arvalid;
  assign w_ar_mask = (32'd1 << AXI_AR_M.arsize) - 32'd1;
  assign w_ar_bad  = (AXI_AR_M.arsize > 3'd2) || (AXI_AR_M.arburst == 2'd3) ||
                     ((AXI_AR_M.arburst == AXI_BURST_WRAP) &&
                      !(AXI_AR_M.arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));

`ifdef RISCV_AXI_RD_UNALIGNED_ERR_EN
  assign w_ar_err  = w_ar_bad || ((AXI_AR_M.araddr & w_ar_mask) != 32'd0);
  assign w_ar_addr = AXI_AR_M.araddr;
`else
  assign w_ar_err  = w_ar_bad;
  assign w_ar_addr = AXI_AR_M.araddr & ~w_ar_mask;
`endif

  // A slot is reserved at issue time, so occupancy already counts the in-flight read.
  assign w_issue     = (r_state == RD_RSP_BURST) && (r_count != 2'd2);
  assign w_pop       = (r_count != 2'd0) && AXI_R_M.rready;
  assign w_rel       = r_addr - BASE_ADDR;
  assign w_in_range  = w_rel < SIZE_BYTES;
  assign w_beat_resp = r_burst_err ? AXI_RESP_SLVERR :
                       (!w_in_range ? AXI_RESP_DECERR : AXI_RESP_OKAY);

  assign mem_rd_en   = w_issue && (w_beat_resp == AXI_RESP_OKAY);
  assign mem_rd_addr = w_rel[MEM_AW+1:2];

  riscv_axi_burst_addr u_burst_addr (
    .i_addr      (r_addr),
    .i_len       (r_len),
    .i_size      (r_size),
    .i_burst     (r_burst),
    .o_next_addr (w_next_addr)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= RD_RSP_IDLE;
      r_id         <= '0;
      r_addr       <= '0;
      r_len        <= '0;
      r_beats_left <= '0;
      r_size       <= '0;
      r_burst      <= '0;
      r_burst_err  <= 1'b0;
    end else begin
      case (r_state)
        RD_RSP_IDLE: if (w_ar_hs) begin
          r_id         <= AXI_AR_M.arid;
          r_addr       <= w_ar_addr;
          r_len        <= AXI_AR_M.arlen;
          r_beats_left <= AXI_AR_M.arlen;
          r_size       <= AXI_AR_M.arsize;
          r_burst      <= AXI_AR_M.arburst;
          r_burst_err  <= w_ar_err;
          r_state      <= RD_RSP_BURST;
        end
        RD_RSP_BURST: if (w_issue) begin
          r_addr <= w_next_addr;
          if (r_beats_left == 8'd0) r_state <= RD_RSP_DRAIN;
          else r_beats_left <= r_beats_left - 8'd1;
        end
        RD_RSP_DRAIN: if (w_pop && r_flast[r_rptr]) r_state <= RD_RSP_IDLE;
        default: r_state <= RD_RSP_IDLE;
      endcase
    end
  end

  // An entry pushed with a memory read captures mem_rd_data one cycle later; until
  // then the R path bypasses the memory output so rvalid appears two cycles after AR.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        r_fdata[i] <= '0;
        r_fresp[i] <= AXI_RESP_OKAY;
        r_flast[i] <= 1'b0;
        r_fpend[i] <= 1'b0;
      end
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_fpend[i]) begin
          r_fdata[i] <= mem_rd_data;
          r_fpend[i] <= 1'b0;
        end
      end
      if (w_issue) begin
        r_fdata[r_wptr] <= '0;
        r_fresp[r_wptr] <= w_beat_resp;
        r_flast[r_wptr] <= (r_beats_left == 8'd0);
        r_fpend[r_wptr] <= mem_rd_en;
        r_wptr          <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_issue} - {1'b0, w_pop};
    end
  end

  assign AXI_AR_S.arready = (r_state == RD_RSP_IDLE);

  always_comb begin
    AXI_R_S        = '0;
    AXI_R_S.rvalid = (r_count != 2'd0);
    AXI_R_S.rid    = r_id;
    AXI_R_S.rdata  = r_fpend[r_rptr] ? mem_rd_data : r_fdata[r_rptr];
    AXI_R_S.rresp  = r_fresp[r_rptr];
    AXI_R_S.rlast  = r_flast[r_rptr];
  end
endmodule

// File: tb/tb_riscv_axi_rd_responder.sv
// tb/tb_riscv_axi_rd_responder.sv - self-checking bench for riscv_axi_rd_responder
module tb_riscv_axi_rd_responder;
  import axi4_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] SIZE = 32'h0001_0000;

  logic        clock = 1'b0;
  logic        reset;
  ar_m         ar;
  r_m          rm;
  ar_s         ars;
  r_s          rs;
  logic        mem_rd_en;
  logic [13:0] mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic [31:0] mem [0:16383];

  int checks = 0;
  int failures = 0;

  logic [31:0] q_data[$];
  logic [1:0]  q_resp[$];
  logic        q_last[$];
  logic [3:0]  q_id[$];
  logic [13:0] q_waddr[$];
  logic [31:0] e_data[$];
  logic [1:0]  e_resp[$];
  logic        e_last[$];
  logic [13:0] e_waddr[$];

  logic        hold_v;
  r_s          hold_s;
  bit          pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  always #5 clock = ~clock;

  riscv_axi_rd_responder #(.BASE_ADDR(BASE), .SIZE_BYTES(SIZE), .MEM_AW(14)) dut (
    .clock       (clock),
    .reset       (reset),
    .AXI_AR_M    (ar),
    .AXI_R_M     (rm),
    .AXI_AR_S    (ars),
    .AXI_R_S     (rs),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data)
  );

  always @(posedge clock) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  always @(negedge clock) begin
    if (!reset) begin
      if (mem_rd_en) q_waddr.push_back(mem_rd_addr);
      if (rs.rvalid && rm.rready) begin
        q_data.push_back(rs.rdata);
        q_resp.push_back(rs.rresp);
        q_last.push_back(rs.rlast);
        q_id.push_back(rs.rid);
      end
    end
  end

  always @(negedge clock) begin
    if (reset) hold_v = 1'b0;
    else begin
      if (hold_v) begin
        checks++;
        if (rs !== hold_s) begin
          failures++;
          $display("FAIL r_stable got %h required %h", rs, hold_s);
        end
      end
      hold_v = rs.rvalid && !rm.rready;
      hold_s = rs;
    end
  end

  task automatic clear_q();
    q_data.delete(); q_resp.delete(); q_last.delete(); q_id.delete(); q_waddr.delete();
  endtask

  // Reference model: beat i address computed directly from the AXI burst rules.
  task automatic build_exp(input logic [31:0] addr0, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a, step, bound, base, ad, off, mask;
    bit err;
    e_data.delete(); e_resp.delete(); e_last.delete(); e_waddr.delete();
    err  = (size > 3'd2) || (burst == 2'd3) ||
           ((burst == 2'd2) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    mask = (32'd1 << size) - 32'd1;
    a    = addr0;
`ifdef RISCV_AXI_RD_UNALIGNED_ERR_EN
    if ((a & mask) != 0) err = 1'b1;
`else
    a = a & ~mask;
`endif
    step  = 32'd1 << size;
    bound = (32'(len) + 32'd1) * step;
    base  = a - (a % bound);
    for (int i = 0; i <= int'(len); i++) begin
      case (burst)
        2'd1:    ad = a + 32'(i) * step;
        2'd2:    ad = base + ((a - base + 32'(i) * step) % bound);
        default: ad = a;
      endcase
      off = ad - BASE;
      if (err) begin
        e_resp.push_back(AXI_RESP_SLVERR); e_data.push_back(32'd0);
      end else if (off >= SIZE) begin
        e_resp.push_back(AXI_RESP_DECERR); e_data.push_back(32'd0);
      end else begin
        e_resp.push_back(AXI_RESP_OKAY); e_data.push_back(mem[off[15:2]]);
        e_waddr.push_back(off[15:2]);
      end
      e_last.push_back(i == int'(len));
    end
  endtask

  // mode 0: random rready, 1: rready held high, 2: fixed backpressure pattern
  task automatic do_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int mode);
    int t;
    clear_q();
    @(posedge clock); #1;
    ar.arvalid = 1'b1; ar.arid = id; ar.araddr = addr; ar.arlen = len;
    ar.arsize = size; ar.arburst = burst;
    rm.rready = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    t = 0;
    while (!ars.arready && t < 100) begin @(posedge clock); #1; t++; end
    @(posedge clock); #1;
    ar.arvalid = 1'b0;
    t = 0;
    while (q_data.size() < int'(len) + 1 && t < 3000) begin
      if (mode == 0) rm.rready = 1'($urandom_range(0, 1));
      else if (mode == 2) rm.rready = (t < 7) ? pat[t] : 1'b1;
      else rm.rready = 1'b1;
      @(posedge clock); #1;
      t++;
    end
    if (t >= 3000) begin
      checks++; failures++;
      $display("FAIL burst_timeout got %0d beats required %0d", q_data.size(), int'(len) + 1);
    end
    rm.rready = 1'b1;
    t = 0;
    while (!ars.arready && t < 20) begin @(posedge clock); #1; t++; end
  endtask

  task automatic test_reset();
    reset = 1'b1; ar = '0; rm = '0;
    #2;
    checks++; if (ars.arready !== 1'b1) begin failures++; $display("FAIL reset_arready got %b required 1", ars.arready); end
    checks++; if (rs.rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got %b required 0", rs.rvalid); end
    checks++; if (rs.rlast !== 1'b0) begin failures++; $display("FAIL reset_rlast got %b required 0", rs.rlast); end
    checks++; if (rs.rresp !== AXI_RESP_OKAY) begin failures++; $display("FAIL reset_rresp got %0d required 0", rs.rresp); end
    checks++; if (mem_rd_en !== 1'b0) begin failures++; $display("FAIL reset_mem_rd_en got %b required 0", mem_rd_en); end
    @(posedge clock); #1; @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_single_latency();
    mem[14'h80] = 32'h0000_0013;
    @(posedge clock); #1;
    ar.arvalid = 1'b1; ar.arid = 4'd1; ar.araddr = 32'h200; ar.arlen = 8'd0;
    ar.arsize = 3'd2; ar.arburst = AXI_BURST_INCR; rm.rready = 1'b1;
    checks++; if (ars.arready !== 1'b1) begin failures++; $display("FAIL lat_arready_n got %b required 1", ars.arready); end
    @(posedge clock); #1;
    ar.arvalid = 1'b0;
    checks++; if (mem_rd_en !== 1'b1 || mem_rd_addr !== 14'h80) begin failures++; $display("FAIL lat_mem_n1 got en=%b addr=%h required en=1 addr=80", mem_rd_en, mem_rd_addr); end
    checks++; if (rs.rvalid !== 1'b0 || ars.arready !== 1'b0) begin failures++; $display("FAIL lat_n1 got rvalid=%b arready=%b required 0 0", rs.rvalid, ars.arready); end
    @(posedge clock); #1;
    checks++; if (rs.rvalid !== 1'b1 || rs.rdata !== 32'h13 || rs.rresp !== AXI_RESP_OKAY || rs.rlast !== 1'b1 || rs.rid !== 4'd1)
      begin failures++; $display("FAIL lat_n2 got v=%b d=%h r=%0d l=%b id=%0d required 1 13 0 1 1", rs.rvalid, rs.rdata, rs.rresp, rs.rlast, rs.rid); end
    @(posedge clock); #1;
    checks++; if (ars.arready !== 1'b1 || rs.rvalid !== 1'b0) begin failures++; $display("FAIL lat_n3 got arready=%b rvalid=%b required 1 0", ars.arready, rs.rvalid); end
  endtask

  task automatic test_incr_backpressure();
    do_burst(4'd3, 32'h200, 8'd3, 3'd2, AXI_BURST_INCR, 2);
    checks++; if (q_data.size() != 4 || q_waddr.size() != 4) begin failures++; $display("FAIL bp_count got beats=%0d reads=%0d required 4 4", q_data.size(), q_waddr.size()); end
    for (int i = 0; i < 4 && i < q_data.size() && i < q_waddr.size(); i++) begin
      checks++;
      if (q_waddr[i] !== 14'(14'h80 + i) || q_data[i] !== mem[14'h80 + i] || q_last[i] !== (i == 3) || q_resp[i] !== AXI_RESP_OKAY)
        begin failures++; $display("FAIL bp_beat%0d got a=%h d=%h l=%b r=%0d required a=%h d=%h l=%b r=0", i, q_waddr[i], q_data[i], q_last[i], q_resp[i], 14'h80 + i, mem[14'h80 + i], i == 3); end
    end
  endtask

  task automatic test_wrap();
    logic [13:0] wa [4] = '{14'h82, 14'h83, 14'h80, 14'h81};
    do_burst(4'd4, 32'h208, 8'd3, 3'd2, AXI_BURST_WRAP, 1);
    checks++; if (q_data.size() != 4 || q_waddr.size() != 4) begin failures++; $display("FAIL wrap_count got beats=%0d reads=%0d required 4 4", q_data.size(), q_waddr.size()); end
    for (int i = 0; i < 4 && i < q_data.size() && i < q_waddr.size(); i++) begin
      checks++;
      if (q_waddr[i] !== wa[i] || q_data[i] !== mem[wa[i]] || q_resp[i] !== AXI_RESP_OKAY)
        begin failures++; $display("FAIL wrap_beat%0d got a=%h d=%h r=%0d required a=%h d=%h r=0", i, q_waddr[i], q_data[i], q_resp[i], wa[i], mem[wa[i]]); end
    end
  endtask

  task automatic test_errors();
    do_burst(4'd6, BASE + SIZE, 8'd1, 3'd2, AXI_BURST_INCR, 0);
    checks++; if (q_data.size() != 2 || q_waddr.size() != 0) begin failures++; $display("FAIL decerr_count got beats=%0d reads=%0d required 2 0", q_data.size(), q_waddr.size()); end
    for (int i = 0; i < 2 && i < q_data.size(); i++) begin
      checks++;
      if (q_resp[i] !== AXI_RESP_DECERR || q_data[i] !== 32'd0 || q_last[i] !== (i == 1) || q_id[i] !== 4'd6)
        begin failures++; $display("FAIL decerr_beat%0d got r=%0d d=%h l=%b id=%0d required 3 0 %b 6", i, q_resp[i], q_data[i], q_last[i], q_id[i], i == 1); end
    end
    do_burst(4'd7, 32'h100, 8'd2, 3'd3, AXI_BURST_INCR, 1);
    checks++; if (q_data.size() != 3 || q_waddr.size() != 0) begin failures++; $display("FAIL slverr_count got beats=%0d reads=%0d required 3 0", q_data.size(), q_waddr.size()); end
    for (int i = 0; i < 3 && i < q_data.size(); i++) begin
      checks++;
      if (q_resp[i] !== AXI_RESP_SLVERR || q_data[i] !== 32'd0)
        begin failures++; $display("FAIL slverr_beat%0d got r=%0d d=%h required 2 0", i, q_resp[i], q_data[i]); end
    end
  endtask

  task automatic test_unaligned();
    logic [1:0]  exp_r;
    logic [31:0] exp_d;
    int          exp_n;
`ifdef RISCV_AXI_RD_UNALIGNED_ERR_EN
    exp_r = AXI_RESP_SLVERR; exp_d = 32'd0; exp_n = 0;
`else
    exp_r = AXI_RESP_OKAY; exp_d = mem[14'h80]; exp_n = 1;
`endif
    do_burst(4'd8, 32'h202, 8'd0, 3'd2, AXI_BURST_INCR, 1);
    checks++;
    if (q_data.size() != 1 || q_waddr.size() != exp_n) begin failures++; $display("FAIL unal_count got beats=%0d reads=%0d required 1 %0d", q_data.size(), q_waddr.size(), exp_n); end
    else if (q_resp[0] !== exp_r || q_data[0] !== exp_d) begin failures++; $display("FAIL unal_beat got r=%0d d=%h required r=%0d d=%h", q_resp[0], q_data[0], exp_r, exp_d); end
  endtask

  task automatic test_random();
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    for (int n = 0; n < 30; n++) begin
      id    = 4'($urandom_range(0, 15));
      size  = 3'($urandom_range(0, 3));
      burst = 2'($urandom_range(0, 2));
      len   = 8'($urandom_range(0, 15));
      if (burst == 2'd2 && $urandom_range(0, 3) != 0) len = 8'((2 << $urandom_range(0, 3)) - 1);
      if ($urandom_range(0, 3) == 0) addr = SIZE - 32'($urandom_range(0, 64));
      else addr = 32'($urandom_range(0, 32'hFFFF));
      build_exp(addr, len, size, burst);
      do_burst(id, addr, len, size, burst, 0);
      checks++;
      if (q_data.size() != e_data.size() || q_waddr.size() != e_waddr.size()) begin
        failures++;
        $display("FAIL rnd%0d_count got beats=%0d reads=%0d required %0d %0d", n, q_data.size(), q_waddr.size(), e_data.size(), e_waddr.size());
      end
      for (int i = 0; i < q_data.size() && i < e_data.size(); i++) begin
        checks++;
        if (q_data[i] !== e_data[i] || q_resp[i] !== e_resp[i] || q_last[i] !== e_last[i] || q_id[i] !== id)
          begin failures++; $display("FAIL rnd%0d_beat%0d got d=%h r=%0d l=%b id=%0d required d=%h r=%0d l=%b id=%0d", n, i, q_data[i], q_resp[i], q_last[i], q_id[i], e_data[i], e_resp[i], e_last[i], id); end
      end
      for (int i = 0; i < q_waddr.size() && i < e_waddr.size(); i++) begin
        checks++;
        if (q_waddr[i] !== e_waddr[i]) begin failures++; $display("FAIL rnd%0d_rdaddr%0d got %h required %h", n, i, q_waddr[i], e_waddr[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int t;
    clear_q();
    @(posedge clock); #1;
    ar.arvalid = 1'b1; ar.arid = 4'd5; ar.araddr = 32'h400; ar.arlen = 8'd7;
    ar.arsize = 3'd2; ar.arburst = AXI_BURST_INCR; rm.rready = 1'b1;
    @(posedge clock); #1;
    ar.arvalid = 1'b0;
    t = 0;
    while (q_data.size() < 1 && t < 50) begin @(posedge clock); #1; t++; end
    checks++; if (t >= 50) begin failures++; $display("FAIL rst_mid_first_beat got 0 beats required 1"); end
    reset = 1'b1;
    #1;
    checks++; if (rs.rvalid !== 1'b0 || ars.arready !== 1'b1 || mem_rd_en !== 1'b0)
      begin failures++; $display("FAIL rst_mid got rvalid=%b arready=%b en=%b required 0 1 0", rs.rvalid, ars.arready, mem_rd_en); end
    @(posedge clock); #1;
    reset = 1'b0;
    build_exp(32'h600, 8'd3, 3'd2, AXI_BURST_INCR);
    do_burst(4'd9, 32'h600, 8'd3, 3'd2, AXI_BURST_INCR, 1);
    checks++; if (q_data.size() != 4) begin failures++; $display("FAIL rst_after_count got %0d required 4", q_data.size()); end
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== e_data[i] || q_id[i] !== 4'd9 || q_resp[i] !== AXI_RESP_OKAY || q_last[i] !== e_last[i])
        begin failures++; $display("FAIL rst_after_beat%0d got d=%h id=%0d r=%0d l=%b required d=%h id=9 r=0 l=%b", i, q_data[i], q_id[i], q_resp[i], q_last[i], e_data[i], e_last[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    test_reset();
    test_single_latency();
    test_incr_backpressure();
    test_wrap();
    test_errors();
    test_unaligned();
    test_random();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
